// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding and the instruction words the sequencer recognises.
package fetch_sequencer_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [XLEN-1:0] EBREAK_INSTR  = 32'h0010_0073;
  localparam logic [6:0]      OPCODE_I_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    LOAD_WB = 2'd2,
    HALT    = 2'd3
  } state_t;

  function automatic logic is_load(input logic [XLEN-1:0] instr);
    return instr[6:0] == OPCODE_I_LOAD;
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-pc selection: JALR target, then pc-relative jump/branch,
// then sequential pc+4. All additions wrap modulo 2^32.
module fetch_pc_next
  import fetch_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            pc_add_sel,
  input  logic            pc_next_sel,
  input  logic [XLEN-1:0] imm_val,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc
);

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    next_pc = pc_plus4;
    if (pc_next_sel) begin
      next_pc = {alu_result[XLEN-1:1], 1'b0};
    end else if (pc_add_sel) begin
      next_pc = pc + imm_val;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer: fetches one word, presents it for a single
// execute cycle, inserts a writeback cycle for loads, and stops for good on EBREAK.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instruction,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  input  logic            pc_add_sel,
  input  logic            pc_next_sel,
  input  logic [XLEN-1:0] imm_val,
  input  logic [XLEN-1:0] alu_result,
  output logic            delayed_load,
  output logic [4:0]      delayed_rd,
  output logic            halted
);

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target_pc;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] instr_d;
  logic [4:0]      rd_d;
  logic            halt_d;

  fetch_pc_next u_pc_next (
    .pc          (pc),
    .pc_add_sel  (pc_add_sel),
    .pc_next_sel (pc_next_sel),
    .imm_val     (imm_val),
    .alu_result  (alu_result),
    .pc_plus4    (pc_plus4),
    .next_pc     (target_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // instruction falls back to NOP every cycle it is not freshly captured, so the
  // decoder only ever sees a real word during EXEC.
  always_comb begin
    state_next = state;
    pc_d       = pc;
    instr_d    = NOP_INSTR;
    rd_d       = delayed_rd;
    halt_d     = halted;
    case (state)
      FETCH: begin
        if (imem_valid) begin
          instr_d    = imem_rdata;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (instruction == EBREAK_INSTR) begin
          halt_d     = 1'b1;
          state_next = HALT;
        end else if (is_load(instruction)) begin
          rd_d       = instruction[11:7];
          state_next = LOAD_WB;
        end else begin
          pc_d       = target_pc;
          state_next = FETCH;
        end
      end
      LOAD_WB: begin
        pc_d       = pc_plus4;
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      instruction <= NOP_INSTR;
      delayed_rd  <= 5'd0;
      halted      <= 1'b0;
    end else begin
      pc          <= pc_d;
      instruction <= instr_d;
      delayed_rd  <= rd_d;
      halted      <= halt_d;
    end
  end

  // Reset parks the FSM in FETCH, so the request is gated to stay quiet while held.
  assign imem_req     = rst && (state == FETCH);
  assign imem_addr    = pc;
  assign instr_valid  = (state == EXEC);
  assign delayed_load = (state == LOAD_WB);

endmodule
